// File: rtl/sigma_multi_generator_pkg.sv
// rtl/sigma_multi_generator_pkg.sv - shared types and defaults for the multi-channel sigma generator
package sigma_multi_generator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIV,
    SQRT,
    STORE,
    DONE
  } sigma_gen_state_t;

  // ICP + photometric
  localparam int SIGMA_GEN_NUM_CH = 2;

  localparam int CLOUD_BW  = 4;
  localparam int H_SIZE_BW = 4;
  localparam int V_SIZE_BW = 4;

endpackage

// File: rtl/sigma_isqrt_seq.sv
// rtl/sigma_isqrt_seq.sv - bit-serial restoring integer square root, one root bit per cycle
module sigma_isqrt_seq #(
  parameter int  IN_BW  = 16,
  localparam int OUT_BW = IN_BW / 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [IN_BW-1:0]  i_radicand,
  output logic              o_done,
  output logic [OUT_BW-1:0] o_root
);

  localparam int CW = $clog2(OUT_BW + 1);

  logic [IN_BW-1:0]  rad_q;
  logic [OUT_BW-1:0] rem_q;
  logic [OUT_BW-1:0] root_q;
  logic [CW-1:0]     cnt_q;
  logic              active_q;

  logic [IN_BW-1:0]  rad_in;
  logic [OUT_BW-1:0] rem_in;
  logic [OUT_BW-1:0] root_in;
  logic [CW-1:0]     cnt_in;
  logic [OUT_BW+1:0] rem_sh;
  logic [OUT_BW+1:0] trial;
  logic              take;

  // The start cycle already performs the first iteration on the fresh radicand,
  // so the whole root takes exactly OUT_BW clock edges.
  always_comb begin
    rad_in  = i_start ? i_radicand : rad_q;
    rem_in  = i_start ? '0 : rem_q;
    root_in = i_start ? '0 : root_q;
    cnt_in  = i_start ? '0 : cnt_q;
    rem_sh  = {rem_in, rad_in[IN_BW-1 -: 2]};
    trial   = {root_in, 2'b01};
    take    = (rem_sh >= trial);
    o_done  = (i_start || active_q) && (cnt_in == CW'(OUT_BW - 1));
  end

  // Iteration registers; the partial remainder stays below 2^OUT_BW until the
  // final step, whose remainder is never used, so truncation is harmless.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (i_start || active_q) begin
      rad_q    <= rad_in << 2;
      rem_q    <= OUT_BW'(take ? (rem_sh - trial) : rem_sh);
      root_q   <= OUT_BW'({root_in, take});
      cnt_q    <= cnt_in + 1'b1;
      active_q <= !o_done;
    end
  end

  assign o_root = root_q;

endmodule

// File: rtl/sigma_multi_generator.sv
// rtl/sigma_multi_generator.sv - per-frame multi-channel sigma = floor(sqrt(sum/count)) with atomic publish
module sigma_multi_generator
  import sigma_multi_generator_pkg::*;
#(
  parameter int  NUM_CH        = SIGMA_GEN_NUM_CH,
  parameter int  SUM_BW        = 4 * CLOUD_BW,
  parameter int  CNT_BW        = H_SIZE_BW + V_SIZE_BW,
  parameter int  ZERO_MODE     = 0,
  parameter int  SIGMA_DEFAULT = 1,
  parameter int  SIGMA_MIN     = 0,
  localparam int SIGMA_BW      = SUM_BW / 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_frame_end,
  input  logic [NUM_CH*SUM_BW-1:0]   i_sum,
  input  logic [NUM_CH*CNT_BW-1:0]   i_count,
  output logic                       o_busy,
  output logic                       o_frame_end,
  output logic [NUM_CH*SIGMA_BW-1:0] o_sigma,
  output logic [NUM_CH-1:0]          o_zero_cnt,
  output logic                       o_overrun
);

  localparam int BC_BW = $clog2(SUM_BW + 1);
  localparam int CH_BW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  sigma_gen_state_t state_q, state_d;

  logic [NUM_CH*SUM_BW-1:0]   sum_q;
  logic [NUM_CH*CNT_BW-1:0]   cnt_q;
  logic [CH_BW-1:0]           ch_q;
  logic [BC_BW-1:0]           bit_q;
  logic [SUM_BW-1:0]          dvd_q;      // dividend shifts out MSB-first, quotient shifts in at LSB
  logic [CNT_BW-1:0]          rem_q;
  logic [NUM_CH*SIGMA_BW-1:0] shadow_sigma_q;
  logic [NUM_CH-1:0]          shadow_zero_q;
  logic [NUM_CH*SIGMA_BW-1:0] sigma_q;
  logic [NUM_CH-1:0]          zero_q;
  logic                       frame_end_q;
  logic                       overrun_q;

  logic                       accept;
  logic                       last_ch;
  logic [CNT_BW-1:0]          divisor;
  logic [CNT_BW:0]            rem_sh;
  logic                       qbit;
  logic [SIGMA_BW-1:0]        cur_sigma;
  logic                       sqrt_start;
  logic                       sqrt_done;
  logic [SIGMA_BW-1:0]        root;

  sigma_isqrt_seq #(
    .IN_BW(SUM_BW)
  ) u_isqrt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (sqrt_start),
    .i_radicand (dvd_q),
    .o_done     (sqrt_done),
    .o_root     (root)
  );

  // Divider step and channel selection; a zero divisor still runs every step
  // so latency never depends on the data.
  always_comb begin
    accept     = i_frame_end && (state_q == IDLE) && !frame_end_q;
    last_ch    = (int'(ch_q) == NUM_CH - 1);
    divisor    = cnt_q[int'(ch_q)*CNT_BW +: CNT_BW];
    rem_sh     = {rem_q, dvd_q[SUM_BW-1]};
    qbit       = (rem_sh >= {1'b0, divisor});
    cur_sigma  = sigma_q[int'(ch_q)*SIGMA_BW +: SIGMA_BW];
    sqrt_start = (state_q == SQRT) && (bit_q == '0);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DIV;
      DIV:     if (bit_q == BC_BW'(SUM_BW - 1)) state_d = SQRT;
      SQRT:    if (sqrt_done) state_d = STORE;
      STORE:   state_d = last_ch ? DONE : DIV;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Shared bit counter: restarts on every DIV/SQRT entry
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bit_q <= '0;
    end else if ((state_q == DIV || state_q == SQRT) && state_d == state_q) begin
      bit_q <= bit_q + 1'b1;
    end else begin
      bit_q <= '0;
    end
  end

  // Datapath: capture, divide, store to shadow, publish all channels at once
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sum_q          <= '0;
      cnt_q          <= '0;
      ch_q           <= '0;
      dvd_q          <= '0;
      rem_q          <= '0;
      shadow_sigma_q <= '0;
      shadow_zero_q  <= '0;
      sigma_q        <= '0;
      zero_q         <= '0;
      frame_end_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      overrun_q   <= i_frame_end && !accept;
      frame_end_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            sum_q <= i_sum;
            cnt_q <= i_count;
            ch_q  <= '0;
            dvd_q <= i_sum[SUM_BW-1:0];
            rem_q <= '0;
          end
        end
        DIV: begin
          dvd_q <= {dvd_q[SUM_BW-2:0], qbit};
          rem_q <= CNT_BW'(qbit ? (rem_sh - {1'b0, divisor}) : rem_sh);
        end
        STORE: begin
          if (divisor == '0) begin
            shadow_zero_q[ch_q] <= 1'b1;
            shadow_sigma_q[int'(ch_q)*SIGMA_BW +: SIGMA_BW] <=
              (ZERO_MODE != 0) ? SIGMA_BW'(SIGMA_DEFAULT) : cur_sigma;
          end else begin
            shadow_zero_q[ch_q] <= 1'b0;
            shadow_sigma_q[int'(ch_q)*SIGMA_BW +: SIGMA_BW] <=
              (root < SIGMA_BW'(SIGMA_MIN)) ? SIGMA_BW'(SIGMA_MIN) : root;
          end
          if (!last_ch) begin
            ch_q  <= ch_q + 1'b1;
            dvd_q <= sum_q[(int'(ch_q) + 1)*SUM_BW +: SUM_BW];
            rem_q <= '0;
          end
        end
        DONE: begin
          sigma_q     <= shadow_sigma_q;
          zero_q      <= shadow_zero_q;
          frame_end_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_frame_end = frame_end_q;
  assign o_sigma     = sigma_q;
  assign o_zero_cnt  = zero_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_sigma_multi_generator.sv
// tb/tb_sigma_multi_generator.sv - bench for sigma_multi_generator across hold, default and clamp configurations
module tb_sigma_multi_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fe_i = 1'b0;
  logic [31:0] sum_i = '0;
  logic [15:0] cnt_i = '0;

  logic        busy [3];
  logic        fe   [3];
  logic [15:0] sig  [3];
  logic [1:0]  zc   [3];
  logic        ovr  [3];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // d0: hold on zero count; d1: default 7 on zero count; d2: hold + clamp at 3
  sigma_multi_generator #(.NUM_CH(2), .SUM_BW(16), .CNT_BW(8), .ZERO_MODE(0), .SIGMA_DEFAULT(1), .SIGMA_MIN(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_end(fe_i), .i_sum(sum_i), .i_count(cnt_i),
    .o_busy(busy[0]), .o_frame_end(fe[0]), .o_sigma(sig[0]), .o_zero_cnt(zc[0]), .o_overrun(ovr[0]));
  sigma_multi_generator #(.NUM_CH(2), .SUM_BW(16), .CNT_BW(8), .ZERO_MODE(1), .SIGMA_DEFAULT(7), .SIGMA_MIN(0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_end(fe_i), .i_sum(sum_i), .i_count(cnt_i),
    .o_busy(busy[1]), .o_frame_end(fe[1]), .o_sigma(sig[1]), .o_zero_cnt(zc[1]), .o_overrun(ovr[1]));
  sigma_multi_generator #(.NUM_CH(2), .SUM_BW(16), .CNT_BW(8), .ZERO_MODE(0), .SIGMA_DEFAULT(1), .SIGMA_MIN(3)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_end(fe_i), .i_sum(sum_i), .i_count(cnt_i),
    .o_busy(busy[2]), .o_frame_end(fe[2]), .o_sigma(sig[2]), .o_zero_cnt(zc[2]), .o_overrun(ovr[2]));

  typedef struct {
    logic [15:0]       sum0;
    logic [7:0]        cnt0;
    logic [15:0]       sum1;
    logic [7:0]        cnt1;
    logic [2:0][15:0]  esig;
    logic [1:0]        z;
  } vec_t;

  typedef struct {
    logic [2:0][15:0]  esig;
    logic [1:0]        z;
    int                edge_no;
  } sb_t;

  vec_t tv [13];
  sb_t  sb_q [$];

  function automatic logic [15:0] pk(input int s0, input int s1);
    return {8'(s1), 8'(s0)};
  endfunction

  task automatic set_vec(input int i, input int s0, input int c0, input int s1, input int c1,
                         input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                         input logic [1:0] z);
    tv[i].sum0 = 16'(s0);
    tv[i].cnt0 = 8'(c0);
    tv[i].sum1 = 16'(s1);
    tv[i].cnt1 = 8'(c1);
    tv[i].esig = {e2, e1, e0};
    tv[i].z    = z;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard consumer: every published frame must match the oldest accepted frame
  always @(negedge clk) begin
    if (fe[0] || fe[1] || fe[2]) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_frame_end", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("frame_end_d%0d", d), 32'(fe[d]), 32'd1);
          chk($sformatf("sigma_d%0d", d), 32'(sig[d]), 32'(e.esig[d]));
          chk($sformatf("zero_cnt_d%0d", d), 32'(zc[d]), 32'(e.z));
        end
        chk("latency", 32'(cyc - e.edge_no), 32'd51);
      end
    end
  end

  task automatic drive(input int i);
    sum_i = {tv[i].sum1, tv[i].sum0};
    cnt_i = {tv[i].cnt1, tv[i].cnt0};
    fe_i  = 1'b1;
  endtask

  task automatic push(input int i);
    sb_t e;
    e.esig    = tv[i].esig;
    e.z       = tv[i].z;
    e.edge_no = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    drive(i);
    push(i);
    @(negedge clk);
    fe_i  = 1'b0;
    sum_i = $urandom;
    cnt_i = 16'($urandom);
    chk($sformatf("busy_rise_v%0d", i), 32'(busy[0]), 32'd1);
    wait_drain();
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_sigma_d%0d", tag, d), 32'(sig[d]), 32'd0);
      chk($sformatf("%s_zero_d%0d", tag, d), 32'(zc[d]), 32'd0);
      chk($sformatf("%s_fe_d%0d", tag, d), 32'(fe[d]), 32'd0);
      chk($sformatf("%s_busy_d%0d", tag, d), 32'(busy[d]), 32'd0);
      chk($sformatf("%s_ovr_d%0d", tag, d), 32'(ovr[d]), 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc;
    int to;

    //          s0     c0   s1     c1   dut0        dut1        dut2        zero
    set_vec(0,  400,   4,   10000, 25,  pk(10,20),  pk(10,20),  pk(10,20),  2'b00);
    set_vec(1,  50,    3,   65535, 1,   pk(4,255),  pk(4,255),  pk(4,255),  2'b00);
    set_vec(2,  400,   4,   77,    0,   pk(10,255), pk(10,7),   pk(10,255), 2'b10);
    set_vec(3,  123,   0,   10000, 25,  pk(10,20),  pk(7,20),   pk(10,20),  2'b01);
    set_vec(4,  4,     1,   0,     5,   pk(2,0),    pk(2,0),    pk(3,3),    2'b00);
    set_vec(5,  2,     1,   1,     1,   pk(1,1),    pk(1,1),    pk(3,3),    2'b00);
    set_vec(6,  5,     0,   9,     0,   pk(1,1),    pk(7,7),    pk(3,3),    2'b11);
    set_vec(7,  65535, 255, 1000,  7,   pk(16,11),  pk(16,11),  pk(16,11),  2'b00);
    set_vec(8,  99,    10,  15,    16,  pk(3,0),    pk(3,0),    pk(3,3),    2'b00);
    set_vec(9,  400,   4,   10000, 25,  pk(10,20),  pk(10,20),  pk(10,20),  2'b00);
    set_vec(10, 50,    3,   65535, 1,   pk(4,255),  pk(4,255),  pk(4,255),  2'b00);
    set_vec(11, 1000,  10,  1000,  10,  pk(0,0),    pk(0,0),    pk(0,0),    2'b00);
    set_vec(12, 10000, 25,  400,   4,   pk(20,10),  pk(20,10),  pk(20,10),  2'b00);

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy[0]), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Overrun mid-frame and coincident with o_frame_end; only the first frame publishes
    @(negedge clk);
    drive(9);
    push(9);
    acc = cyc + 1;
    @(negedge clk);
    fe_i = 1'b0;
    chk("ovr_quiet", 32'(ovr[0]), 32'd0);
    while (cyc < acc + 19) @(negedge clk);
    sum_i = 32'h1234_5678;
    cnt_i = 16'h0101;
    fe_i  = 1'b1;
    @(negedge clk);
    fe_i = 1'b0;
    chk("ovr_mid", 32'(ovr[0]), 32'd1);
    chk("ovr_mid_busy", 32'(busy[0]), 32'd1);
    @(negedge clk);
    chk("ovr_mid_clear", 32'(ovr[0]), 32'd0);
    to = 0;
    while (!fe[0] && to < 100) begin
      @(negedge clk);
      to++;
    end
    chk("ovr_wait_timeout", 32'(to < 100), 32'd1);
    fe_i = 1'b1;
    @(negedge clk);
    fe_i = 1'b0;
    chk("ovr_done", 32'(ovr[0]), 32'd1);
    chk("ovr_done_not_busy", 32'(busy[0]), 32'd0);
    repeat (60) @(negedge clk);
    run_vec(10);

    // Reset in the middle of a computation
    @(negedge clk);
    drive(11);
    acc = cyc + 1;
    @(negedge clk);
    fe_i = 1'b0;
    while (cyc < acc + 29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    run_vec(12);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
